// File: rtl/filter_sched_pkg.sv
// filter_sched shared types and constants.
// Tag width is sized for the largest supported channel count.
package filter_sched_pkg;

  localparam int TAPS    = 5;
  localparam int HIST    = TAPS - 1;
  localparam int DEF_DW  = 8;
  localparam int DEF_NCH = 4;
  localparam int CHW_MAX = 4;

  typedef struct packed {
    logic               valid;
    logic [CHW_MAX-1:0] ch;
  } tag_t;

endpackage

// File: rtl/filter_sched_if.sv
// Sample-request and tagged-result bundle for filter_sched.
// master = stream source/sink side, slave = scheduler.
interface filter_sched_if #(
  parameter int NCH = 4,
  parameter int DW  = 8,
  parameter int CHW = $clog2(NCH)
);

  logic [NCH-1:0]    in_valid;
  logic [NCH*DW-1:0] in_data;
  logic [NCH-1:0]    in_ready;
  logic              out_valid;
  logic [DW-1:0]     out_data;
  logic [CHW-1:0]    out_ch;

  modport master (
    output in_valid, in_data,
    input  in_ready, out_valid, out_data, out_ch
  );

  modport slave (
    input  in_valid, in_data,
    output in_ready, out_valid, out_data, out_ch
  );

endinterface

// File: rtl/rr_arbiter.sv
// Rotating-priority arbiter: first requester at or after ptr wins.
// Purely combinational; caller owns the pointer register.
module rr_arbiter #(
  parameter int NCH = 4,
  parameter int CHW = $clog2(NCH)
) (
  input  logic [NCH-1:0] req,
  input  logic [CHW-1:0] ptr,
  output logic [NCH-1:0] gnt,
  output logic [CHW-1:0] gnt_idx,
  output logic           any
);

  logic [CHW:0]   pos;
  logic [CHW-1:0] idx;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    any     = 1'b0;
    pos     = '0;
    idx     = '0;
    for (int i = 0; i < NCH; i++) begin
      pos = {1'b0, ptr} + (CHW+1)'(i);
      if (pos >= (CHW+1)'(NCH))
        pos = pos - (CHW+1)'(NCH);
      idx = pos[CHW-1:0];
      if (!any && req[idx]) begin
        any      = 1'b1;
        gnt[idx] = 1'b1;
        gnt_idx  = idx;
      end
    end
  end

endmodule

// File: rtl/filter_sched.sv
// Time-shares one 5-tap filter across NCH sample streams,
// keeping per-channel history and tagging results by channel.
module filter_sched
  import filter_sched_pkg::*;
#(
  parameter int NCH      = DEF_NCH,
  parameter int DW       = DEF_DW,
  parameter int FILT_LAT = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  filter_sched_if.slave bus,
  output logic [DW-1:0] distortedInputm4,
  output logic [DW-1:0] distortedInputm3,
  output logic [DW-1:0] distortedInputm2,
  output logic [DW-1:0] distortedInputm1,
  output logic [DW-1:0] distortedInput,
  input  logic [DW-1:0] filteredOutput
);

  localparam int CHW = $clog2(NCH);

  logic [CHW-1:0] ptr;
  logic [CHW-1:0] gntIdx;
  logic [CHW-1:0] nextPtr;
  logic [NCH-1:0] gnt;
  logic           any;
  logic           accept;
  logic [DW-1:0]  sample;

  // hist[c][HIST-1] is the newest sample (m1), hist[c][0] the oldest (m4)
  logic [DW-1:0] hist [NCH][HIST];

  tag_t tagIn;
  tag_t tagPipe [FILT_LAT+1];
  tag_t tail;
  logic unusedTagBits;

  logic           outValid;
  logic [DW-1:0]  outData;
  logic [CHW-1:0] outCh;

  rr_arbiter #(.NCH(NCH), .CHW(CHW)) uArb (
    .req     (bus.in_valid),
    .ptr     (ptr),
    .gnt     (gnt),
    .gnt_idx (gntIdx),
    .any     (any)
  );

  assign bus.in_ready = (rst || clear) ? '0 : gnt;
  assign accept       = any && !clear;
  assign sample       = bus.in_data[gntIdx*DW +: DW];
  assign nextPtr      = (gntIdx == CHW'(NCH-1)) ? '0
                      : gntIdx + CHW'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr              <= '0;
      distortedInputm4 <= '0;
      distortedInputm3 <= '0;
      distortedInputm2 <= '0;
      distortedInputm1 <= '0;
      distortedInput   <= '0;
      for (int c = 0; c < NCH; c++)
        for (int k = 0; k < HIST; k++)
          hist[c][k] <= '0;
    end else if (clear) begin
      ptr <= '0;
      for (int c = 0; c < NCH; c++)
        for (int k = 0; k < HIST; k++)
          hist[c][k] <= '0;
    end else if (accept) begin
      ptr              <= nextPtr;
      distortedInputm4 <= hist[gntIdx][0];
      distortedInputm3 <= hist[gntIdx][1];
      distortedInputm2 <= hist[gntIdx][2];
      distortedInputm1 <= hist[gntIdx][3];
      distortedInput   <= sample;
      for (int k = 0; k < HIST-1; k++)
        hist[gntIdx][k] <= hist[gntIdx][k+1];
      hist[gntIdx][HIST-1] <= sample;
    end
  end

  always_comb begin
    tagIn             = '0;
    tagIn.valid       = accept;
    tagIn.ch[CHW-1:0] = gntIdx;
  end

  // Tag rides alongside the filter so it lines up with its result
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i <= FILT_LAT; i++)
        tagPipe[i] <= '0;
    end else begin
      tagPipe[0] <= tagIn;
      for (int i = 1; i <= FILT_LAT; i++)
        tagPipe[i] <= tagPipe[i-1];
    end
  end

  assign tail          = tagPipe[FILT_LAT];
  assign unusedTagBits = ^tail.ch;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      outValid <= 1'b0;
      outData  <= '0;
      outCh    <= '0;
    end else begin
      outValid <= tail.valid;
      outData  <= filteredOutput;
      outCh    <= tail.ch[CHW-1:0];
    end
  end

  assign bus.out_valid = outValid;
  assign bus.out_data  = outData;
  assign bus.out_ch    = outCh;

endmodule

// File: tb/tb_filter_sched.sv
// Bench for filter_sched with a registered sum-of-taps mock filter.
// Table-driven steps plus hand sequences; results via scoreboard.
module tb_filter_sched;

  localparam int NCH = 4;
  localparam int DW  = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic clear = 1'b0;
  logic [DW-1:0] m4, m3, m2, m1, din, filt;

  filter_sched_if #(.NCH(NCH), .DW(DW)) bus ();

  filter_sched #(.NCH(NCH), .DW(DW), .FILT_LAT(1)) dut (
    .clk              (clk),
    .rst              (rst),
    .clear            (clear),
    .bus              (bus),
    .distortedInputm4 (m4),
    .distortedInputm3 (m3),
    .distortedInputm2 (m2),
    .distortedInputm1 (m1),
    .distortedInput   (din),
    .filteredOutput   (filt)
  );

  always #5 clk = ~clk;

  always_ff @(posedge clk or posedge rst)
    if (rst) filt <= '0;
    else     filt <= m4 + m3 + m2 + m1 + din;

  typedef struct {
    logic [3:0]  v;
    logic [31:0] d;
    logic [3:0]  rdy;
    logic        clr;
  } vec_t;

  typedef struct {
    logic [1:0] ch;
    logic [7:0] data;
  } exp_t;

  vec_t tbl[$];
  exp_t sbq[$];
  logic [7:0] mh [4][4];
  int nChecks = 0;
  int nFail = 0;
  int run = 0;
  int maxRun = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %0h expected %0h",
               nm, act, exp);
    end
  endtask

  function automatic vec_t mk(
    logic [3:0] v, logic [7:0] d0, logic [7:0] d1,
    logic [7:0] d2, logic [7:0] d3, logic [3:0] r,
    logic c);
    vec_t t;
    t.v = v;
    t.d = {d3, d2, d1, d0};
    t.rdy = r;
    t.clr = c;
    return t;
  endfunction

  task automatic clrModel();
    for (int c = 0; c < 4; c++)
      for (int k = 0; k < 4; k++)
        mh[c][k] = '0;
  endtask

  // One clock: drive at negedge, check grant, check taps after edge
  task automatic step(input vec_t t);
    int g;
    logic [7:0] s;
    logic [7:0] e[5];
    exp_t x;
    bit doTap;
    @(negedge clk);
    bus.in_valid = t.v;
    bus.in_data  = t.d;
    clear        = t.clr;
    #1;
    chk("in_ready", {28'd0, bus.in_ready}, {28'd0, t.rdy});
    doTap = 0;
    g = 0;
    if (t.rdy != 0) begin
      for (int i = 0; i < 4; i++)
        if (t.rdy[i]) g = i;
      s = t.d[g*8 +: 8];
      e[0] = mh[g][0];
      e[1] = mh[g][1];
      e[2] = mh[g][2];
      e[3] = mh[g][3];
      e[4] = s;
      x.ch = 2'(g);
      x.data = e[0] + e[1] + e[2] + e[3] + e[4];
      sbq.push_back(x);
      mh[g][0] = mh[g][1];
      mh[g][1] = mh[g][2];
      mh[g][2] = mh[g][3];
      mh[g][3] = s;
      doTap = 1;
    end
    if (t.clr) clrModel();
    @(posedge clk);
    #1;
    bus.in_valid = '0;
    clear = 1'b0;
    if (doTap) begin
      chk("tap_m4", {24'd0, m4}, {24'd0, e[0]});
      chk("tap_m3", {24'd0, m3}, {24'd0, e[1]});
      chk("tap_m2", {24'd0, m2}, {24'd0, e[2]});
      chk("tap_m1", {24'd0, m1}, {24'd0, e[3]});
      chk("tap_in", {24'd0, din}, {24'd0, e[4]});
    end
  endtask

  always @(posedge clk) begin
    exp_t x;
    #1;
    if (bus.out_valid === 1'b1) begin
      run++;
      if (run > maxRun) maxRun = run;
      if (sbq.size() == 0) begin
        nChecks++;
        nFail++;
        $display("FAIL unexpected_out: got ch %0d data %0h expected none",
                 bus.out_ch, bus.out_data);
      end else begin
        x = sbq.pop_front();
        chk("out_ch", {30'd0, bus.out_ch}, {30'd0, x.ch});
        chk("out_data", {24'd0, bus.out_data},
            {24'd0, x.data});
      end
    end else begin
      run = 0;
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    clrModel();
    bus.in_valid = 4'b1111;
    bus.in_data  = '0;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", {28'd0, bus.in_ready}, 32'd0);
    chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("rst_out_data", {24'd0, bus.out_data}, 32'd0);
    chk("rst_out_ch", {30'd0, bus.out_ch}, 32'd0);
    chk("rst_taps", {m4, m3, m2, din}, 32'd0);
    bus.in_valid = '0;
    rst = 1'b0;

    // single sample after reset, with latency check
    step(mk(4'b0001, 8'd7, 0, 0, 0, 4'b0001, 0));
    @(posedge clk);
    #1;
    chk("lat_e1_valid", {31'd0, bus.out_valid}, 32'd0);
    @(posedge clk);
    #1;
    chk("lat_e2_valid", {31'd0, bus.out_valid}, 32'd1);

    // history fill on ch1, then ch0 history untouched
    for (int k = 1; k <= 5; k++)
      tbl.push_back(mk(4'b0010, 0, 8'(k), 0, 0, 4'b0010, 0));
    tbl.push_back(mk(4'b0001, 8'd10, 0, 0, 0, 4'b0001, 0));
    // full contention from ptr=0
    tbl.push_back(mk(4'b0000, 0, 0, 0, 0, 4'b0000, 1));
    for (int k = 0; k < 8; k++)
      tbl.push_back(mk(4'b1111, 8'h11, 8'h22, 8'h33, 8'h44,
                       4'(1 << (k % 4)), 0));
    // rotation skip
    tbl.push_back(mk(4'b0010, 0, 8'h55, 0, 0, 4'b0010, 0));
    tbl.push_back(mk(4'b1001, 8'h66, 0, 0, 8'h77, 4'b1000, 0));
    tbl.push_back(mk(4'b1001, 8'h66, 0, 0, 8'h77, 4'b0001, 0));
    // clear with a request pending
    tbl.push_back(mk(4'b0000, 0, 0, 0, 0, 4'b0000, 1));
    for (int k = 1; k <= 4; k++)
      tbl.push_back(mk(4'b0001, 8'(k), 0, 0, 0, 4'b0001, 0));
    tbl.push_back(mk(4'b0001, 8'd9, 0, 0, 0, 4'b0000, 1));
    tbl.push_back(mk(4'b0001, 8'd9, 0, 0, 0, 4'b0001, 0));

    for (int i = 0; i < tbl.size(); i++)
      step(tbl[i]);
    repeat (4) @(posedge clk);
    #2;
    chk("contiguous_run", {31'd0, maxRun >= 8}, 32'd1);

    // async reset with results in flight
    step(mk(4'b0100, 0, 0, 8'd5, 0, 4'b0100, 0));
    step(mk(4'b0100, 0, 0, 8'd6, 0, 4'b0100, 0));
    step(mk(4'b0100, 0, 0, 8'd7, 0, 4'b0100, 0));
    #2;
    rst = 1'b1;
    #1;
    chk("async_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("async_out_data", {24'd0, bus.out_data}, 32'd0);
    sbq.delete();
    clrModel();
    bus.in_valid = 4'b0100;
    @(negedge clk);
    chk("async_in_ready", {28'd0, bus.in_ready}, 32'd0);
    @(negedge clk);
    bus.in_valid = '0;
    rst = 1'b0;
    step(mk(4'b0100, 0, 0, 8'd6, 0, 4'b0100, 0));

    for (int i = 0; i < 20 && sbq.size() != 0; i++)
      @(posedge clk);
    repeat (3) @(posedge clk);
    #2;
    chk("drain", sbq.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             nChecks, nFail);
    $finish;
  end

endmodule
